// File: rtl/dnn_fixed_pkg.sv
// Shared fixed-point definitions for the DNN junction pipeline: word format,
// the constant 1.0, saturation and the multiply-shift used by every processor set.
package dnn_fixed_pkg;

  localparam int unsigned INT_BITS  = 5;
  localparam int unsigned FRAC_BITS = 10;
  localparam int unsigned WIDTH     = 1 + INT_BITS + FRAC_BITS;

  // diff = a - y needs one extra bit; the product of a diff and a word needs 2*WIDTH+1.
  localparam int unsigned DIFF_W = WIDTH + 1;
  localparam int unsigned PROD_W = 2 * WIDTH + 1;

  typedef logic signed [WIDTH-1:0]  fx_t;
  typedef logic signed [DIFF_W-1:0] fx_diff_t;
  typedef logic signed [PROD_W-1:0] fx_prod_t;

  localparam fx_t      ONE     = fx_t'(1 << FRAC_BITS);
  localparam fx_prod_t SAT_MAX = fx_prod_t'(2 ** (WIDTH - 1) - 1);
  localparam fx_prod_t SAT_MIN = fx_prod_t'(-(2 ** (WIDTH - 1)));

  // Clamp a wide signed value into a single fixed-point word.
  function automatic fx_t sat_fx(input fx_prod_t v);
    if (v > SAT_MAX) begin
      return fx_t'(SAT_MAX);
    end else if (v < SAT_MIN) begin
      return fx_t'(SAT_MIN);
    end else begin
      return fx_t'(v);
    end
  endfunction

  // Full-precision product rescaled to FRAC_BITS; the arithmetic shift truncates toward -inf.
  function automatic fx_prod_t fx_mul_shift(input fx_diff_t a, input fx_t b);
    fx_prod_t p;
    p = fx_prod_t'(a) * fx_prod_t'(b);
    return p >>> FRAC_BITS;
  endfunction

endpackage

// File: rtl/output_delta_unit_if.sv
// Beat-level bus between the last feedforward junction, the output delta unit
// and the backprop/update sets. Lanes = z/fi neurons per beat.
interface output_delta_unit_if #(
  parameter int unsigned Lanes = 2,
  parameter int unsigned Width = 16,
  parameter int unsigned IdxW  = 3
);

  logic                   in_valid;
  logic [Lanes*Width-1:0] sigmoid_package;
  logic [Lanes*Width-1:0] sp_package;
  logic [Lanes-1:0]       y_package;
  logic                   out_valid;
  logic [Lanes*Width-1:0] delta_package;
  logic                   result_valid;
  logic [IdxW-1:0]        pred_index;
  logic                   correct;

  // Upstream side: supplies activations/targets, observes deltas and results.
  modport master (
    output in_valid, sigmoid_package, sp_package, y_package,
    input  out_valid, delta_package, result_valid, pred_index, correct
  );

  // Delta unit side.
  modport slave (
    input  in_valid, sigmoid_package, sp_package, y_package,
    output out_valid, delta_package, result_valid, pred_index, correct
  );

endinterface

// File: rtl/argmax_tracker.sv
// Per-input classification tracker: walks the n output activations chunk by chunk,
// keeps the running signed max and the first target index, and reports
// pred_index/correct two cycles after the last chunk so it lines up with its delta.
module argmax_tracker import dnn_fixed_pkg::*; #(
  parameter int unsigned N     = 8,
  parameter int unsigned Lanes = 2,
  parameter int unsigned IdxW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_valid,
  input  logic [Lanes*WIDTH-1:0] i_act,
  input  logic [Lanes-1:0]       i_y,
  output logic                   o_result_valid,
  output logic [IdxW-1:0]        o_pred_index,
  output logic                   o_correct
);

  localparam int unsigned C    = N / Lanes;
  localparam int unsigned CntW = (C > 1) ? $clog2(C) : 1;

  logic [CntW-1:0] r_cnt;
  fx_t             r_max;
  logic [IdxW-1:0] r_idx;
  logic [IdxW-1:0] r_tgt;
  logic            r_found;

  logic            r_res1;
  logic [IdxW-1:0] r_pred1;
  logic            r_corr1;

  logic            r_result_valid;
  logic [IdxW-1:0] r_pred;
  logic            r_correct;

  fx_t             w_act [Lanes];
  fx_t             w_max;
  logic [IdxW-1:0] w_idx;
  logic [IdxW-1:0] w_tgt;
  logic            w_found;
  logic            w_first;
  logic            w_last;

  // Fold this beat's lanes, lowest index first, into the running max and target latch.
  always_comb begin
    w_first = (r_cnt == '0);
    w_last  = (r_cnt == CntW'(C - 1));
    w_max   = r_max;
    w_idx   = r_idx;
    w_tgt   = r_tgt;
    w_found = r_found;
    for (int unsigned k = 0; k < Lanes; k++) begin
      w_act[k] = fx_t'(i_act[k*WIDTH +: WIDTH]);
    end
    for (int unsigned k = 0; k < Lanes; k++) begin
      // Lane 0 of chunk 0 seeds the max so all-negative inputs still resolve correctly.
      if ((w_first && (k == 0)) || (w_act[k] > w_max)) begin
        w_max = w_act[k];
        w_idx = IdxW'(32'(r_cnt) * Lanes + k);
      end
      if (!w_found && i_y[k]) begin
        w_found = 1'b1;
        w_tgt   = IdxW'(32'(r_cnt) * Lanes + k);
      end
    end
  end

  // Advance on accepted beats only; the last chunk closes out the input and clears the trackers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_max   <= '0;
      r_idx   <= '0;
      r_tgt   <= '0;
      r_found <= 1'b0;
      r_res1  <= 1'b0;
      r_pred1 <= '0;
      r_corr1 <= 1'b0;
    end else begin
      r_res1 <= 1'b0;
      if (i_valid) begin
        if (w_last) begin
          r_cnt   <= '0;
          r_max   <= '0;
          r_idx   <= '0;
          r_tgt   <= '0;
          r_found <= 1'b0;
          r_res1  <= 1'b1;
          r_pred1 <= w_idx;
          r_corr1 <= w_found && (w_idx == w_tgt);
        end else begin
          r_cnt   <= r_cnt + 1'b1;
          r_max   <= w_max;
          r_idx   <= w_idx;
          r_tgt   <= w_tgt;
          r_found <= w_found;
        end
      end
    end
  end

  // Second stage so result_valid coincides with out_valid of the final beat.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_result_valid <= 1'b0;
      r_pred         <= '0;
      r_correct      <= 1'b0;
    end else begin
      r_result_valid <= r_res1;
      if (r_res1) begin
        r_pred    <= r_pred1;
        r_correct <= r_corr1;
      end
    end
  end

  assign o_result_valid = r_result_valid;
  assign o_pred_index   = r_pred;
  assign o_correct      = r_correct;

endmodule

// File: rtl/output_delta_unit.sv
// Output-layer delta unit: delta = (a - y) * f'(s), two-stage pipeline, one beat per cycle,
// plus argmax classification via argmax_tracker.
// Build option CROSS_ENTROPY_EN: delta = sat(a - y), sp ignored, no multiplier; latency stays 2.
module output_delta_unit import dnn_fixed_pkg::*; #(
  parameter int unsigned N  = 8,
  parameter int unsigned Z  = 8,
  parameter int unsigned FI = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output_delta_unit_if.slave   bus
);

  localparam int unsigned LANES = Z / FI;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  fx_diff_t               w_diff  [LANES];
  fx_diff_t               r_diff  [LANES];
  fx_t                    w_delta [LANES];
  logic                   r_valid1;
  logic                   r_out_valid;
  logic [LANES*WIDTH-1:0] r_delta;

  logic                   w_result_valid;
  logic [IDX_W-1:0]       w_pred_index;
  logic                   w_correct;

  // Stage 1 input: subtract the target (1.0 or 0.0) from each activation.
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      w_diff[k] = fx_diff_t'(fx_t'(bus.sigmoid_package[k*WIDTH +: WIDTH]))
                - (bus.y_package[k] ? fx_diff_t'(ONE) : '0);
    end
  end

  // Stage 1 register: diff and its valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid1 <= 1'b0;
      for (int unsigned k = 0; k < LANES; k++) begin
        r_diff[k] <= '0;
      end
    end else begin
      r_valid1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_diff <= w_diff;
      end
    end
  end

`ifdef CROSS_ENTROPY_EN
  logic w_unused_sp;
  assign w_unused_sp = ^bus.sp_package;

  // Stage 2 input: the diff itself is the delta, clamped to one word.
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      w_delta[k] = sat_fx(fx_prod_t'(r_diff[k]));
    end
  end
`else
  fx_t r_sp [LANES];

  // Stage 1 register: f'(s) travels alongside its diff.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        r_sp[k] <= '0;
      end
    end else if (bus.in_valid) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        r_sp[k] <= fx_t'(bus.sp_package[k*WIDTH +: WIDTH]);
      end
    end
  end

  // Stage 2 input: scale by f'(s), rescale and clamp.
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      w_delta[k] = sat_fx(fx_mul_shift(r_diff[k], r_sp[k]));
    end
  end
`endif

  // Stage 2 register: delta output and its valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_delta     <= '0;
    end else begin
      r_out_valid <= r_valid1;
      if (r_valid1) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          r_delta[k*WIDTH +: WIDTH] <= w_delta[k];
        end
      end
    end
  end

  argmax_tracker #(
    .N     (N),
    .Lanes (LANES),
    .IdxW  (IDX_W)
  ) u_argmax (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_valid        (bus.in_valid),
    .i_act          (bus.sigmoid_package),
    .i_y            (bus.y_package),
    .o_result_valid (w_result_valid),
    .o_pred_index   (w_pred_index),
    .o_correct      (w_correct)
  );

  assign bus.out_valid     = r_out_valid;
  assign bus.delta_package = r_delta;
  assign bus.result_valid  = w_result_valid;
  assign bus.pred_index    = w_pred_index;
  assign bus.correct       = w_correct;

endmodule

// File: tb/tb_output_delta_unit.sv
// Directed bench for output_delta_unit at n=8, z=8, fi=4 (2 lanes, 4 chunks per input).
module tb_output_delta_unit;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  output_delta_unit_if #(.Lanes(2), .Width(16), .IdxW(3)) bus ();

  output_delta_unit #(.N(8), .Z(8), .FI(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive_beat(input logic [15:0] a0, input logic [15:0] a1,
                            input logic [15:0] sp0, input logic [15:0] sp1,
                            input logic [1:0] y);
    bus.in_valid        = 1'b1;
    bus.sigmoid_package = {a1, a0};
    bus.sp_package      = {sp1, sp0};
    bus.y_package       = y;
    step();
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n             = 1'b0;
    bus.in_valid        = 1'b0;
    bus.sigmoid_package = '0;
    bus.sp_package      = '0;
    bus.y_package       = '0;
    step();
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    checks++; if (bus.delta_package !== 32'h0) begin errors++; $display("FAIL reset_delta: got %h want 0", bus.delta_package); end
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid: got %0b want 0", bus.result_valid); end
    checks++; if (bus.pred_index !== 3'd0) begin errors++; $display("FAIL reset_pred: got %0d want 0", bus.pred_index); end
    checks++; if (bus.correct !== 1'b0) begin errors++; $display("FAIL reset_correct: got %0b want 0", bus.correct); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic_delta();
    logic [31:0] exp_a;
    logic [31:0] exp_b;
`ifdef CROSS_ENTROPY_EN
    exp_a = {16'h0200, 16'hFF00};
    exp_b = {16'h012C, 16'hFFFF};
`else
    exp_a = {16'h0080, 16'hFFD0};
    exp_b = {16'hFED4, 16'hFFFF};
`endif
    do_reset();
    // Beat A: lane0 0.75 vs target 1, sp 0.1875; lane1 0.5 vs 0, sp 0.25.
    drive_beat(16'd768, 16'd512, 16'd192, 16'd256, 2'b01);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency1: out_valid %0b want 0", bus.out_valid); end
    // Beat B back-to-back: -1 LSB times tiny sp truncates to -1; 300 times -1.0.
    drive_beat(16'd1023, 16'd300, 16'd1, 16'hFC00, 2'b01);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency2: out_valid %0b want 1", bus.out_valid); end
    checks++; if (bus.delta_package !== exp_a) begin errors++; $display("FAIL basic_delta_a: got %h want %h", bus.delta_package, exp_a); end
    idle(1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_b2b_valid: out_valid %0b want 1", bus.out_valid); end
    checks++; if (bus.delta_package !== exp_b) begin errors++; $display("FAIL basic_delta_b: got %h want %h", bus.delta_package, exp_b); end
    idle(1);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: out_valid %0b want 0", bus.out_valid); end
  endtask

  task automatic test_saturation();
    do_reset();
    drive_beat(16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 2'b10);
    idle(1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sat_valid: out_valid %0b want 1", bus.out_valid); end
    checks++; if (bus.delta_package[15:0] !== 16'h7FFF) begin errors++; $display("FAIL sat_pos: got %h want 7fff", bus.delta_package[15:0]); end
    checks++; if (bus.delta_package[31:16] !== 16'h8000) begin errors++; $display("FAIL sat_neg: got %h want 8000", bus.delta_package[31:16]); end
  endtask

  // Two inputs back-to-back, max at index 5; first targets 5, second targets 2.
  task automatic test_back_to_back();
    logic [15:0] ta0 [8];
    logic [15:0] ta1 [8];
    logic [1:0]  ty  [8];
    logic        exp_rv;
    ta0 = '{16'd100, 16'hFFCE, 16'd250, 16'd800, 16'd100, 16'hFFCE, 16'd250, 16'd800};
    ta1 = '{16'd200, 16'd300,  16'd900, 16'd899, 16'd200, 16'd300,  16'd900, 16'd899};
    ty  = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    do_reset();
    for (int b = 0; b < 8; b++) begin
      drive_beat(ta0[b], ta1[b], 16'd1024, 16'd1024, ty[b]);
      exp_rv = (b == 4);
      checks++; if (bus.result_valid !== exp_rv) begin errors++; $display("FAIL b2b_rv beat %0d: got %0b want %0b", b, bus.result_valid, exp_rv); end
      if (b >= 1) begin
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid beat %0d: got %0b want 1", b, bus.out_valid); end
      end
      if (b == 4) begin
        checks++; if (bus.pred_index !== 3'd5) begin errors++; $display("FAIL b2b_pred1: got %0d want 5", bus.pred_index); end
        checks++; if (bus.correct !== 1'b1) begin errors++; $display("FAIL b2b_correct1: got %0b want 1", bus.correct); end
      end
    end
    idle(1);
    checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL b2b_rv_end: got %0b want 1", bus.result_valid); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_last_valid: got %0b want 1", bus.out_valid); end
    checks++; if (bus.delta_package !== {16'd899, 16'd800}) begin errors++; $display("FAIL b2b_last_delta: got %h want %h", bus.delta_package, {16'd899, 16'd800}); end
    checks++; if (bus.pred_index !== 3'd5) begin errors++; $display("FAIL b2b_pred2: got %0d want 5", bus.pred_index); end
    checks++; if (bus.correct !== 1'b0) begin errors++; $display("FAIL b2b_correct2: got %0b want 0", bus.correct); end
    idle(1);
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL b2b_rv_pulse: got %0b want 0", bus.result_valid); end
    checks++; if (bus.pred_index !== 3'd5) begin errors++; $display("FAIL b2b_pred_hold: got %0d want 5", bus.pred_index); end
  endtask

  // Equal maxima at indices 1 and 6, two idle cycles after every beat.
  task automatic test_tie_gaps();
    logic [15:0] ta0 [4];
    logic [15:0] ta1 [4];
    logic [1:0]  ty  [4];
    int          pulses;
    int          valids;
    logic [2:0]  pred_seen;
    logic        corr_seen;
    ta0 = '{16'd10, 16'hFFFD, 16'd0, 16'd500};
    ta1 = '{16'd500, 16'd499, 16'hFE0C, 16'd100};
    ty  = '{2'b00, 2'b00, 2'b00, 2'b01};
    pulses = 0; valids = 0; pred_seen = '0; corr_seen = 1'b0;
    do_reset();
    for (int b = 0; b < 4; b++) begin
      drive_beat(ta0[b], ta1[b], 16'd1024, 16'd1024, ty[b]);
      for (int g = 0; g < 3; g++) begin
        if (bus.result_valid === 1'b1) begin
          pulses++; pred_seen = bus.pred_index; corr_seen = bus.correct;
        end
        if (bus.out_valid === 1'b1) valids++;
        if (g < 2) idle(1);
      end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL tie_pulses: got %0d want 1", pulses); end
    checks++; if (valids !== 4) begin errors++; $display("FAIL tie_out_valids: got %0d want 4", valids); end
    checks++; if (pred_seen !== 3'd1) begin errors++; $display("FAIL tie_pred: got %0d want 1", pred_seen); end
    checks++; if (corr_seen !== 1'b0) begin errors++; $display("FAIL tie_correct: got %0b want 0", corr_seen); end
  endtask

  // No target bit at all, then an all-negative input whose max is at index 3.
  task automatic test_boundaries();
    do_reset();
    drive_beat(16'd300, 16'd0, 16'd1024, 16'd1024, 2'b00);
    drive_beat(16'd0, 16'd0, 16'd1024, 16'd1024, 2'b00);
    drive_beat(16'd0, 16'd0, 16'd1024, 16'd1024, 2'b00);
    drive_beat(16'd0, 16'd0, 16'd1024, 16'd1024, 2'b00);
    idle(1);
    checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL noy_rv: got %0b want 1", bus.result_valid); end
    checks++; if (bus.pred_index !== 3'd0) begin errors++; $display("FAIL noy_pred: got %0d want 0", bus.pred_index); end
    checks++; if (bus.correct !== 1'b0) begin errors++; $display("FAIL noy_correct: got %0b want 0", bus.correct); end
    drive_beat(16'hFC18, 16'hFC18, 16'd1024, 16'd1024, 2'b00);
    drive_beat(16'hFC18, 16'hFFFB, 16'd1024, 16'd1024, 2'b10);
    drive_beat(16'hFC18, 16'hFC18, 16'd1024, 16'd1024, 2'b00);
    drive_beat(16'hFC18, 16'hFC18, 16'd1024, 16'd1024, 2'b00);
    idle(1);
    checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL neg_rv: got %0b want 1", bus.result_valid); end
    checks++; if (bus.pred_index !== 3'd3) begin errors++; $display("FAIL neg_pred: got %0d want 3", bus.pred_index); end
    checks++; if (bus.correct !== 1'b1) begin errors++; $display("FAIL neg_correct: got %0b want 1", bus.correct); end
    idle(2);
  endtask

  // Entered with pred_index=3/correct=1 still showing from the previous input.
  task automatic test_reset_mid();
    int         pulses;
    logic [2:0] pred_seen;
    logic       corr_seen;
    pulses = 0; pred_seen = '0; corr_seen = 1'b0;
    drive_beat(16'd5000, 16'd0, 16'd1024, 16'd1024, 2'b01);
    drive_beat(16'd0, 16'd0, 16'd1024, 16'd1024, 2'b00);
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b want 0", bus.out_valid); end
    checks++; if (bus.delta_package !== 32'h0) begin errors++; $display("FAIL mid_rst_delta: got %h want 0", bus.delta_package); end
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_rv: got %0b want 0", bus.result_valid); end
    checks++; if (bus.pred_index !== 3'd0) begin errors++; $display("FAIL mid_rst_pred: got %0d want 0", bus.pred_index); end
    checks++; if (bus.correct !== 1'b0) begin errors++; $display("FAIL mid_rst_correct: got %0b want 0", bus.correct); end
    reset_n = 1'b1;
    idle(1);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_inflight: out_valid %0b want 0", bus.out_valid); end
    for (int b = 0; b < 7; b++) begin
      if (b < 3) drive_beat(16'd1, 16'd1, 16'd1024, 16'd1024, 2'b00);
      else if (b == 3) drive_beat(16'd700, 16'd1, 16'd1024, 16'd1024, 2'b01);
      else idle(1);
      if (bus.result_valid === 1'b1) begin
        pulses++; pred_seen = bus.pred_index; corr_seen = bus.correct;
      end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL mid_pulses: got %0d want 1", pulses); end
    checks++; if (pred_seen !== 3'd6) begin errors++; $display("FAIL mid_pred: got %0d want 6", pred_seen); end
    checks++; if (corr_seen !== 1'b1) begin errors++; $display("FAIL mid_correct: got %0b want 1", corr_seen); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic_delta();
    test_saturation();
    test_back_to_back();
    test_tie_gaps();
    test_boundaries();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
